approx_mult_err_monitor: RTL and testbench
==========================================

Name: approx_mult_err_monitor

Overview:
- Downstream evaluation stage for the 8x8 approximate multipliers.
- Takes the operands and the approximate product R from the multiplier under test and recomputes the exact product internally.
- Accumulates error statistics over a programmed number of samples: error count, sum of error distance, signed error sum, and maximum error distance with the operands that caused it.
- Results are held for readout, for characterising each multiplier configuration in simulation or on FPGA.

Parameters:
- W, 8, operand width; product width is 2W.
- CNT_W, 16, sample counter width.
- ACC_W, 2*W+CNT_W, accumulator width; sized so accumulators cannot overflow.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; clears statistics and begins a run.
- num_samples  in  CNT_W  samples per run; sampled on an accepted start.
- in_valid  in  1  operand/product beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- op_a  in  W  multiplicand fed to the multiplier.
- op_b  in  W  multiplier operand.
- approx_r  in  2W  approximate product from the multiplier.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; statistics are final.
- sample_cnt  out  CNT_W  samples processed.
- err_cnt  out  CNT_W  samples with approx_r != exact product.
- sum_ed  out  ACC_W  sum of |approx - exact|.
- sum_sed  out  ACC_W+1  signed sum of (approx - exact), two's complement.
- max_ed  out  2W  largest error distance seen.
- max_a  out  W  op_a of the max_ed sample.
- max_b  out  W  op_b of the max_ed sample.

Behaviour:
- Reset: all outputs 0, including in_ready, busy and done; FSM goes to IDLE; pipeline valids cleared.
- Reset asserted mid-run: the run is aborted immediately with no partial results retained.
- FSM states:
  - IDLE: waits for start.
  - RUN: accepts beats.
  - DRAIN: pipeline emptying.
  - DONE: results held.
- FSM transitions:
  - IDLE/DONE + start: clear all statistics, latch num_samples into target, clear the accepted counter, go to RUN.
  - If the latched target is 0: go to DONE the next cycle with all statistics 0.
  - start in RUN or DRAIN: ignored.
  - RUN: in_ready = 1 while accepted < target. A beat is accepted when in_valid & in_ready.
  - RUN: on the accept that makes accepted == target, go to DRAIN; in_ready goes low the following cycle.
  - DRAIN: go to DONE once both pipeline stages are empty, i.e. 2 cycles after the last accept.
  - DONE: done = 1 and statistics hold until the next start.
- Pipeline:
  - Stage 1 (accept edge): register op_a, op_b, approx_r, valid.
  - Stage 2: compute exact = a*b (2W, unsigned), diff = approx - exact (2W+1, signed), ed = |diff| (2W).
  - Stage 2 register: statistics update. An accepted beat is visible on the outputs 2 clock edges after its accept edge.
- Statistics update per processed sample:
  - sample_cnt += 1.
  - err_cnt += (diff != 0).
  - sum_ed += ed, zero-extended.
  - sum_sed += diff, sign-extended.
  - If ed > max_ed (strict): max_ed <= ed, max_a/max_b <= that sample's operands. Ties keep the earliest sample.
- No overflow: ACC_W covers (2^CNT_W - 1)*(2^2W - 1), so no saturation logic is needed.
- Bubbles: in_valid low in RUN inserts bubbles; a bubble updates no statistic.
- Beats offered while in_ready = 0: not consumed; the source must hold them.

Decomposition:
- Package approx_mult_pkg holds:
  - FSM state enum (IDLE, RUN, DRAIN, DONE), 2 bits.
  - Default W/CNT_W constants.
  - A function for ACC_W.
- Sub-module err_dist_calc (combinational): inputs a, b, approx; outputs exact, diff, ed. It is instantiated in stage 2 so the error arithmetic can be reused by other evaluation blocks.

Test Plan:
- Exact sample: start with num_samples=1, beat a=15, b=15, approx_r=225 → done; sample_cnt=1, err_cnt=0, sum_ed=0, sum_sed=0, max_ed=0, max_a=0, max_b=0.
- Under-estimate: num_samples=1, a=255, b=255, approx_r=64512 (exact 65025) → err_cnt=1, sum_ed=513, sum_sed=-513, max_ed=513, max_a=255, max_b=255.
- Tie handling:
  - Stimulus: num_samples=3; beats (a=2,b=2,R=8), (a=3,b=3,R=19), (a=5,b=1,R=15); errors +4, +10, +10.
  - Response: sum_ed=24, sum_sed=24, max_ed=10, max_a=3, max_b=3.
- Backpressure and bubbles:
  - Stimulus: num_samples=4; in_valid pattern 1,0,1,1,1,1,1 with all-exact data.
  - Response: in_ready low after the 4th accept; sample_cnt=4; done 2 cycles after the 4th accept; the 5th and 6th beats are not consumed.
- Zero target: start with num_samples=0 → done=1 on the cycle after start; all statistics 0; busy never high.
- Reset and ignored start:
  - Pulse start during RUN → no effect on target or counts.
  - Drop rst_n mid-RUN → all outputs 0 immediately, asynchronously; after release the FSM is in IDLE and a new run completes normally.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Shared types and constants for the approximate-multiplier evaluation blocks.
package approx_mult_pkg;

  localparam int unsigned DefaultW    = 8;
  localparam int unsigned DefaultCntW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  // Accumulator width that holds (2^cnt_w - 1) * (2^(2w) - 1) without overflow.
  function automatic int unsigned acc_width(input int unsigned w, input int unsigned cnt_w);
    return 2 * w + cnt_w;
  endfunction

endpackage

// File: rtl/err_dist_calc.sv
// Exact product and error distance of an approximate product (combinational).
module err_dist_calc
  import approx_mult_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic [W-1:0]          a,
  input  logic [W-1:0]          b,
  input  logic [2*W-1:0]        approx,
  output logic [2*W-1:0]        exact,
  output logic signed [2*W:0]   diff,
  output logic [2*W-1:0]        ed
);

  // |approx - exact| always fits in 2W bits since both operands are 2W-bit unsigned.
  always_comb begin
    exact = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    diff  = $signed({1'b0, approx}) - $signed({1'b0, exact});
    ed    = diff[2*W] ? (2*W)'(-diff) : (2*W)'(diff);
  end

endmodule

// File: rtl/approx_mult_err_monitor.sv
// Error-statistics monitor for 8x8 approximate multipliers: recomputes the exact
// product and accumulates error count, error-distance sums and the worst sample.
module approx_mult_err_monitor
  import approx_mult_pkg::*;
#(
  parameter int unsigned W     = DefaultW,
  parameter int unsigned CNT_W = DefaultCntW,
  parameter int unsigned ACC_W = acc_width(W, CNT_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       op_a,
  input  logic [W-1:0]       op_b,
  input  logic [2*W-1:0]     approx_r,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [ACC_W-1:0]   sum_ed,
  output logic [ACC_W:0]     sum_sed,
  output logic [2*W-1:0]     max_ed,
  output logic [W-1:0]       max_a,
  output logic [W-1:0]       max_b
);

  state_e             state_q;
  logic [CNT_W-1:0]   target_q, acc_cnt_q;

  logic               s1_valid_q;
  logic [W-1:0]       s1_a_q, s1_b_q;
  logic [2*W-1:0]     s1_r_q;

  logic [CNT_W-1:0]   sample_cnt_q, err_cnt_q;
  logic [ACC_W-1:0]   sum_ed_q;
  logic [ACC_W:0]     sum_sed_q;
  logic [2*W-1:0]     max_ed_q;
  logic [W-1:0]       max_a_q, max_b_q;

  logic               accept, start_ok;
  logic [2*W-1:0]     exact;
  logic signed [2*W:0] diff;
  logic [2*W-1:0]     ed;

  assign in_ready = (state_q == StRun) && (acc_cnt_q < target_q);
  assign accept   = in_valid & in_ready;
  assign start_ok = start & ((state_q == StIdle) || (state_q == StDone));
  assign busy     = (state_q == StRun) || (state_q == StDrain);
  assign done     = (state_q == StDone);

  // Run control: latch target, count accepted beats, sequence IDLE/RUN/DRAIN/DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      target_q  <= '0;
      acc_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            target_q  <= num_samples;
            acc_cnt_q <= '0;
            state_q   <= (num_samples == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          if (accept) begin
            acc_cnt_q <= acc_cnt_q + CNT_W'(1);
            if (acc_cnt_q + CNT_W'(1) == target_q) state_q <= StDrain;
          end
        end
        // DRAIN is entered with exactly the last beat in stage 1; it retires on this edge.
        StDrain: state_q <= StDone;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stage 1: capture the accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_r_q     <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_a_q <= op_a;
        s1_b_q <= op_b;
        s1_r_q <= approx_r;
      end
    end
  end

  err_dist_calc #(
    .W (W)
  ) u_err_dist_calc (
    .a      (s1_a_q),
    .b      (s1_b_q),
    .approx (s1_r_q),
    .exact  (exact),
    .diff   (diff),
    .ed     (ed)
  );

  // Stage 2: fold one sample into the statistics; a new run clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      sum_ed_q     <= '0;
      sum_sed_q    <= '0;
      max_ed_q     <= '0;
      max_a_q      <= '0;
      max_b_q      <= '0;
    end else if (start_ok) begin
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      sum_ed_q     <= '0;
      sum_sed_q    <= '0;
      max_ed_q     <= '0;
      max_a_q      <= '0;
      max_b_q      <= '0;
    end else if (s1_valid_q) begin
      sample_cnt_q <= sample_cnt_q + CNT_W'(1);
      err_cnt_q    <= err_cnt_q + {{(CNT_W-1){1'b0}}, (diff != '0)};
      sum_ed_q     <= sum_ed_q + {{(ACC_W-2*W){1'b0}}, ed};
      sum_sed_q    <= sum_sed_q + {{(ACC_W-2*W){diff[2*W]}}, diff};
      // Strict compare: ties keep the earliest sample.
      if (ed > max_ed_q) begin
        max_ed_q <= ed;
        max_a_q  <= s1_a_q;
        max_b_q  <= s1_b_q;
      end
    end
  end

  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign sum_ed     = sum_ed_q;
  assign sum_sed    = sum_sed_q;
  assign max_ed     = max_ed_q;
  assign max_a      = max_a_q;
  assign max_b      = max_b_q;

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Directed bench for approx_mult_err_monitor with hand-computed expectations.
module tb_approx_mult_err_monitor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num_samples;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [15:0] approx_r;
  logic        busy;
  logic        done;
  logic [15:0] sample_cnt;
  logic [15:0] err_cnt;
  logic [31:0] sum_ed;
  logic [32:0] sum_sed;
  logic [15:0] max_ed;
  logic [7:0]  max_a;
  logic [7:0]  max_b;

  int n_checks = 0;
  int n_pass   = 0;

  approx_mult_err_monitor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .approx_r    (approx_r),
    .busy        (busy),
    .done        (done),
    .sample_cnt  (sample_cnt),
    .err_cnt     (err_cnt),
    .sum_ed      (sum_ed),
    .sum_sed     (sum_sed),
    .max_ed      (max_ed),
    .max_a       (max_a),
    .max_b       (max_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n);
    start       = 1'b1;
    num_samples = n;
    tick();
    start       = 1'b0;
  endtask

  // Offer one beat and hold it until it is accepted (bounded).
  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic [15:0] r);
    int k = 0;
    op_a     = a;
    op_b     = b;
    approx_r = r;
    in_valid = 1'b1;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    if (!in_ready) check_eq("beat_accept_timeout", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 20) begin
      tick();
      k++;
    end
    check_eq("done_reached", done, 1);
  endtask

  task automatic check_stats(input string tag, input int sc, input int ec, input int sed,
                             input longint ssed, input int med, input int ma, input int mb);
    check_eq({tag, "_sample_cnt"}, sample_cnt, sc);
    check_eq({tag, "_err_cnt"}, err_cnt, ec);
    check_eq({tag, "_sum_ed"}, sum_ed, sed);
    check_eq({tag, "_sum_sed"}, 64'($signed(sum_sed)), ssed);
    check_eq({tag, "_max_ed"}, max_ed, med);
    check_eq({tag, "_max_a"}, max_a, ma);
    check_eq({tag, "_max_b"}, max_b, mb);
  endtask

  initial begin
    logic [6:0] pat;
    int acc;
    int last;

    rst_n       = 1'b0;
    start       = 1'b0;
    num_samples = '0;
    in_valid    = 1'b0;
    op_a        = '0;
    op_b        = '0;
    approx_r    = '0;
    tick();
    tick();
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_stats("rst", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_busy", busy, 0);
    check_eq("idle_in_ready", in_ready, 0);

    // Exact sample
    do_start(16'd1);
    check_eq("t1_busy", busy, 1);
    check_eq("t1_in_ready", in_ready, 1);
    send_beat(8'd15, 8'd15, 16'd225);
    wait_done();
    check_stats("t1", 1, 0, 0, 0, 0, 0, 0);

    // Under-estimate: 64512 - 65025 = -513
    do_start(16'd1);
    send_beat(8'd255, 8'd255, 16'd64512);
    wait_done();
    check_stats("t2", 1, 1, 513, -513, 513, 255, 255);

    // Ties: errors +4, +10, +10; the first 10 wins
    do_start(16'd3);
    send_beat(8'd2, 8'd2, 16'd8);
    send_beat(8'd3, 8'd3, 16'd19);
    send_beat(8'd5, 8'd1, 16'd15);
    wait_done();
    check_stats("t3", 3, 3, 24, 24, 10, 3, 3);

    // Backpressure and bubbles: valid 1,0,1,1,1,1,1 against a target of 4
    do_start(16'd4);
    pat  = 7'b1111101;
    acc  = 0;
    last = 100;
    for (int c = 0; c < 7; c++) begin
      in_valid = pat[c];
      op_a     = 8'(c + 1);
      op_b     = 8'd3;
      approx_r = 16'((c + 1) * 3);
      check_eq("bp_in_ready", in_ready, (acc < 4) ? 1 : 0);
      check_eq("bp_done", done, (c >= last + 2) ? 1 : 0);
      if (in_valid && in_ready) begin
        acc++;
        if (acc == 4) last = c;
      end
      tick();
    end
    in_valid = 1'b0;
    tick();
    check_eq("bp_done_final", done, 1);
    check_stats("bp", 4, 0, 0, 0, 0, 0, 0);

    // Zero target: straight to DONE with cleared statistics
    do_start(16'd0);
    check_eq("z_done", done, 1);
    check_eq("z_busy", busy, 0);
    check_eq("z_in_ready", in_ready, 0);
    check_stats("z", 0, 0, 0, 0, 0, 0, 0);

    // start during RUN is ignored
    do_start(16'd3);
    send_beat(8'd2, 8'd2, 16'd8);
    do_start(16'd1);
    check_eq("ign_busy", busy, 1);
    check_eq("ign_sample_cnt", sample_cnt, 1);
    send_beat(8'd3, 8'd3, 16'd19);
    check_eq("ign_still_ready", in_ready, 1);
    send_beat(8'd5, 8'd1, 16'd15);
    wait_done();
    check_stats("ign", 3, 3, 24, 24, 10, 3, 3);

    // Asynchronous reset mid-run
    do_start(16'd2);
    send_beat(8'd255, 8'd255, 16'd64512);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_busy", busy, 0);
    check_eq("ar_in_ready", in_ready, 0);
    check_eq("ar_done", done, 0);
    check_stats("ar", 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("ar_idle_busy", busy, 0);
    check_eq("ar_idle_done", done, 0);
    do_start(16'd1);
    send_beat(8'd255, 8'd255, 16'd64512);
    wait_done();
    check_stats("ar_rerun", 1, 1, 513, -513, 513, 255, 255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
